// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper and its capture bank.
// Mask slices are laid out function-major: function k owns bits [k*N_VEC +: N_VEC].
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N_IN = 4;
  localparam int N_VEC    = 2**DEF_N_IN;

  // Minterm sets of the exercise functions C, D and E (bit m = output at minterm m)
  localparam logic [15:0] MASK_C = 16'h90D6;
  localparam logic [15:0] MASK_D = 16'h3526;
  localparam logic [15:0] MASK_E = 16'h22A5;

  // Base bit of function k's slice inside a packed mask bus
  function automatic int mask_slice(input int k, input int n_vec);
    return k * n_vec;
  endfunction

endpackage

// File: rtl/tt_capture_bank.sv
// Per-function minterm capture registers with indexed write and clear, plus the
// XOR-reduce compare against the expected masks; results register on check_en.
module tt_capture_bank
  import tt_pkg::*;
#(
  parameter int N_FN  = 5,
  parameter int IDX_W = 4,
  parameter int N_VEC = 2**IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [N_FN-1:0]         wr_dat,
  input  logic                    check_en,
  input  logic [N_FN*N_VEC-1:0]   exp_mask,
  output logic [N_FN*N_VEC-1:0]   cap_mask,
  output logic [N_FN-1:0]         mismatch,
  output logic                    pass
);

  logic [N_FN-1:0] mismatch_nxt;

  for (genvar k = 0; k < N_FN; k++) begin : g_fn
    localparam int BASE = mask_slice(k, N_VEC);
    logic [N_VEC-1:0] cap_q;

    always_ff @(posedge clk) begin
      if (reset || clear) begin
        cap_q <= '0;
      end else if (wr_en) begin
        cap_q[wr_idx] <= wr_dat[k];
      end
    end

    assign cap_mask[BASE +: N_VEC] = cap_q;
    assign mismatch_nxt[k]         = |(cap_q ^ exp_mask[BASE +: N_VEC]);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mismatch <= '0;
      pass     <= 1'b0;
    end else if (check_en) begin
      mismatch <= mismatch_nxt;
      pass     <= ~|mismatch_nxt;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector through the functions-under-test, holding each for
// SETTLE+1 cycles and capturing on the last one, then compares against exp_mask.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_FN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             vec_out,
  input  logic [N_FN-1:0]             fn_in,
  input  logic [N_FN*(2**N_IN)-1:0]   exp_mask,
  output logic [N_FN*(2**N_IN)-1:0]   cap_mask,
  output logic [N_FN-1:0]             mismatch,
  output logic                        busy,
  output logic                        done,
  output logic                        pass
);

  localparam int              NV       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       sample, last_vec, launch, cancel;

  assign sample   = (state == DRIVE) && (settle_cnt == 4'd0);
  assign last_vec = (vec_out == LAST_VEC);
  // abort wins over a coincident start; abort in DONE lets the results stand
  assign launch   = (state == IDLE) && start && !abort;
  assign cancel   = abort && ((state == DRIVE) || (state == CHECK));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = DRIVE;
      DRIVE:   if (abort) state_nxt = IDLE;
               else if (sample && last_vec) state_nxt = CHECK;
      CHECK:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE, CHECK: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  // vec_out parks on the last vector after a sweep and only moves on start/abort
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_out    <= '0;
      settle_cnt <= '0;
    end else if (launch) begin
      vec_out    <= '0;
      settle_cnt <= SETTLE_L;
    end else if (cancel) begin
      vec_out    <= '0;
      settle_cnt <= '0;
    end else if (state == DRIVE) begin
      if (!sample) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else if (!last_vec) begin
        vec_out    <= vec_out + 1'b1;
        settle_cnt <= SETTLE_L;
      end
    end
  end

  tt_capture_bank #(
    .N_FN  (N_FN),
    .IDX_W (N_IN),
    .N_VEC (NV)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch || cancel),
    .wr_en    (sample),
    .wr_idx   (vec_out),
    .wr_dat   (fn_in),
    .check_en (state == CHECK),
    .exp_mask (exp_mask),
    .cap_mask (cap_mask),
    .mismatch (mismatch),
    .pass     (pass)
  );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table of sweeps with a scoreboard of expected
// results, plus abort, reset, idle start/abort and SETTLE=3 sequences.
module tb_truth_table_sweeper;
  import tt_pkg::*;

  localparam int N_IN = 4;
  localparam int N_FN = 5;
  localparam int NV   = 16;
  localparam int W    = N_FN * NV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, abort, start3, abort3;
  logic [N_FN-1:0] fn_in, fn_in3, mismatch, mismatch3;
  logic [N_IN-1:0] vec_out, vec_out3;
  logic [W-1:0]    exp_mask, cap_mask, cap_mask3;
  logic            busy, done, pass, busy3, done3, pass3;

  truth_table_sweeper #(.N_IN(N_IN), .N_FN(N_FN), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .vec_out(vec_out),
    .fn_in(fn_in), .exp_mask(exp_mask), .cap_mask(cap_mask), .mismatch(mismatch),
    .busy(busy), .done(done), .pass(pass)
  );

  truth_table_sweeper #(.N_IN(N_IN), .N_FN(N_FN), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .vec_out(vec_out3),
    .fn_in(fn_in3), .exp_mask(exp_mask), .cap_mask(cap_mask3), .mismatch(mismatch3),
    .busy(busy3), .done(done3), .pass(pass3)
  );

  int checks = 0;
  int errors = 0;
  int flt_fn = -1;
  int flt_vec = 0;
  int ph3 = 0;

  typedef struct {
    int          fault_fn;
    int          fault_vec;
    logic        exp_pass;
    logic [4:0]  exp_mm;
    logic [15:0] exp_c;
    bit          abort_in_done;
  } vec_t;

  typedef struct {
    logic        exp_pass;
    logic [4:0]  exp_mm;
    logic [15:0] exp_c;
    logic [W-1:0] exp_cap;
    int          exp_lat;
  } exp_t;

  vec_t tbl[5];
  exp_t sb[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Ideal function model; dut3 sees random garbage except on its sample cycle
  always @(negedge clk) begin
    logic [NV-1:0] sl;
    if (!busy3) ph3 = 0;
    else ph3++;
    for (int k = 0; k < N_FN; k++) begin
      sl = exp_mask[k*NV +: NV];
      fn_in[k] = sl[vec_out];
      if (k == flt_fn && int'(vec_out) == flt_vec) fn_in[k] = ~fn_in[k];
      fn_in3[k] = (ph3 % 4 == 0) ? sl[vec_out3] : 1'($urandom);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, W'(vec_out), W'(0));
    chk({tag, "_cap"}, cap_mask, '0);
    chk({tag, "_mm"}, W'(mismatch), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_pass"}, W'(pass), W'(0));
  endtask

  // Start at cycle t, a stray start in DRIVE, wait for done, compare with scoreboard
  task automatic sweep(input vec_t v);
    exp_t e;
    int   k;
    e.exp_pass = v.exp_pass;
    e.exp_mm   = v.exp_mm;
    e.exp_c    = v.exp_c;
    e.exp_cap  = exp_mask;
    if (v.fault_fn >= 0) e.exp_cap[v.fault_fn*NV + v.fault_vec] = ~exp_mask[v.fault_fn*NV + v.fault_vec];
    e.exp_lat  = 34;
    flt_fn  = v.fault_fn;
    flt_vec = v.fault_vec;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_pass_cleared", W'(pass), W'(0));
    chk("t1_mm_cleared", W'(mismatch), W'(0));
    chk("t1_cap_cleared", cap_mask, '0);
    while (done !== 1'b1 && k < 200) begin
      start = (k == 9);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_latency", W'(k), W'(e.exp_lat));
    chk("done_busy", W'(busy), W'(0));
    chk("pass", W'(pass), W'(e.exp_pass));
    chk("mismatch", W'(mismatch), W'(e.exp_mm));
    chk("cap_c", W'(cap_mask[15:0]), W'(e.exp_c));
    chk("cap_mask", cap_mask, e.exp_cap);
    abort = v.abort_in_done;
    @(negedge clk);
    abort = 1'b0;
    chk("post_done", W'(done), W'(0));
    chk("post_pass_held", W'(pass), W'(e.exp_pass));
    chk("post_mm_held", W'(mismatch), W'(e.exp_mm));
    chk("post_vec_held", W'(vec_out), W'(NV - 1));
  endtask

  initial begin
    int k;
    int ndone;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    exp_mask = {16'hFFFF, 16'h0000, MASK_E, MASK_D, MASK_C};
    tbl[0] = '{-1, 0,  1'b1, 5'b00000, 16'h90D6, 1'b0};
    tbl[1] = '{ 0, 5,  1'b0, 5'b00001, 16'h90F6, 1'b1};
    tbl[2] = '{ 4, 15, 1'b0, 5'b10000, 16'h90D6, 1'b0};
    tbl[3] = '{ 2, 0,  1'b0, 5'b00100, 16'h90D6, 1'b0};
    tbl[4] = '{-1, 0,  1'b1, 5'b00000, 16'h90D6, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back sweeps: each start is raised the cycle after the previous done
    for (int i = 0; i < 5; i++) sweep(tbl[i]);

    // start with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_start_abort_busy", W'(busy), W'(0));

    // Abort at t+10
    flt_fn = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_vec", W'(vec_out), W'(0));
    chk("abort_cap", cap_mask, '0);
    chk("abort_pass", W'(pass), W'(0));
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", W'(ndone), W'(0));
    sweep(tbl[0]);

    // Reset at t+20 with start held through reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("rst_held_busy", W'(busy), W'(0));
    reset = 1'b0;
    sweep(tbl[0]);

    // SETTLE=3 with garbage on non-sample cycles, stray start at t+5
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    k = 1;
    while (done3 !== 1'b1 && k < 300) begin
      if (k == 4) chk("s3_vec0_hold", W'(vec_out3), W'(0));
      if (k == 5) chk("s3_vec1", W'(vec_out3), W'(1));
      start3 = (k == 5);
      @(negedge clk);
      k++;
    end
    start3 = 1'b0;
    chk("s3_done_latency", W'(k), W'(66));
    chk("s3_pass", W'(pass3), W'(1));
    chk("s3_mm", W'(mismatch3), W'(0));
    chk("s3_cap", cap_mask3, exp_mask);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
